ifid_hazard_ctrl: RTL

//  Hazard/stall controller for the 5-stage MIPS pipeline. Drives the IF/ID register's hold/IF_flush pair,
//  the PC hold and the ID/EX bubble. Arbitrates load-use stalls, I-mem miss waits, D-mem freezes and

---
 rtl/ifid_hazard_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: IF/ID hazard and stall controller for the 5-stage MIPS pipeline.
//   Inputs : id_rs/id_rt/id_uses_rt (ID sources), ex_mem_read/ex_rt (load in EX),
//            id_branch_tkn, imem_ready, dmem_busy.
//   Outputs: pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze (same-cycle controls),
//            imiss_timeout (sticky), hz_state (debug), stall_cnt/flush_cnt (perf).
//   Define HAZ_PERF_CNT_EN to build the perf counters; otherwise they read as zero.
module ifid_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_branch_tkn,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             imiss_timeout,
  output logic [1:0]       hz_state,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);
  typedef enum logic [1:0] {S_RUN = 2'd0, S_IMISS = 2'd1, S_FREEZE = 2'd2} state_t;
  state_t st_q, st_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  logic load_use;
  logic [4:0] ctl;
  assign load_use = ex_mem_read && ex_rt != '0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  // ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}; a masked branch simply
  // stays in the held IF/ID register and flushes on its first unmasked cycle.
  always_comb begin
    ctl = rst                        ? 5'b11110 :
          dmem_busy                  ? 5'b11001 :
          (load_use || !imem_ready)  ? 5'b11010 :
          id_branch_tkn              ? 5'b01100 : 5'b00000;
    st_d = dmem_busy ? S_FREEZE : !imem_ready ? S_IMISS : S_RUN;
    cnt_d = imem_ready ? '0 :
            (dmem_busy || cnt_q == WAIT_W'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
    to_d = to_q || cnt_d == WAIT_W'(MAX_WAIT);
  end
  assign {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze} = ctl;
  assign imiss_timeout = to_q;
  assign hz_state = st_q;
  // st_d only ever takes legal encodings, so an upset into 2'd3 falls back to S_RUN next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S_RUN;
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(pc_hold && !(&stall_q));
      flush_q <= flush_q + 16'(ifid_flush && !(&flush_q));
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
